// File: rtl/branch_seq_pkg.sv
// Shared encodings for the branch sequencer: state codes, opcodes, control bundle.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package branch_seq_pkg;

  typedef enum logic [3:0] {
    RESET_ST = 4'd0,
    T0       = 4'd1,
    T1       = 4'd2,
    T2       = 4'd3,
    T3       = 4'd4,
    T4       = 4'd5,
    T5       = 4'd6,
    T6       = 4'd7,
    HALTED   = 4'd8
  } state_t;

  localparam logic [4:0] BR   = 5'b10010;
  localparam logic [4:0] NOP  = 5'b11010;
  localparam logic [4:0] HALT = 5'b11011;

  typedef struct packed {
    logic pc_out;
    logic mar_in;
    logic inc_pc;
    logic z_in;
    logic zlow_out;
    logic pc_in;
    logic read;
    logic mdr_in;
    logic mdr_out;
    logic ir_in;
    logic gra;
    logic r_out;
    logic con_in;
    logic con_ff_reset;
    logic y_in;
    logic c_out;
    logic add;
    logic halted;
  } ctrl_t;

  function automatic logic [4:0] opcode_of(input logic [31:0] ir);
    return ir[31:27];
  endfunction

endpackage

// File: rtl/branch_sequencer_if.sv
// Sequencer inputs (run, IR, condition, memory done) and the control/debug outputs.
// Latency: n/a (wiring only).
// Backpressure: none; mem_done is the only stall source.
interface branch_sequencer_if;
  logic        run;
  logic [31:0] IR;
  logic        CON_out;
  logic        mem_done;

  logic PCout, MARin, IncPC, Zin, Zlowout, PCin, Read, MDRin, MDRout;
  logic IRin, Gra, Rout, CONin, con_FF_Reset, Yin, Cout, ADD, halted;
  logic [3:0] state;

  modport master (
    output run, IR, CON_out, mem_done,
    input  PCout, MARin, IncPC, Zin, Zlowout, PCin, Read, MDRin, MDRout,
    input  IRin, Gra, Rout, CONin, con_FF_Reset, Yin, Cout, ADD, halted, state
  );

  modport slave (
    input  run, IR, CON_out, mem_done,
    output PCout, MARin, IncPC, Zin, Zlowout, PCin, Read, MDRin, MDRout,
    output IRin, Gra, Rout, CONin, con_FF_Reset, Yin, Cout, ADD, halted, state
  );
endinterface

// File: rtl/branch_seq_decode.sv
// Moore control decode: state (+ opcode in T3, CON_out in T6, first-T1 flag) to control lines.
// Latency: combinational.
// Backpressure: none.
module branch_seq_decode
  import branch_seq_pkg::*;
(
  input  state_t     state,
  input  logic [4:0] opcode,
  input  logic       con_out,
  input  logic       first_t1,
  output ctrl_t      ctrl
);

  always_comb begin
    ctrl = '0;
    case (state)
      T0: begin
        ctrl.pc_out = 1'b1;
        ctrl.mar_in = 1'b1;
        ctrl.inc_pc = 1'b1;
        ctrl.z_in   = 1'b1;
      end
      T1: begin
        ctrl.zlow_out = 1'b1;
        ctrl.read     = 1'b1;
        ctrl.mdr_in   = 1'b1;
        // Latching the incremented PC once keeps long memory waits from re-incrementing it.
        ctrl.pc_in    = first_t1;
      end
      T2: begin
        ctrl.mdr_out      = 1'b1;
        ctrl.ir_in        = 1'b1;
        ctrl.con_ff_reset = 1'b1;
      end
      T3: begin
        if (opcode == BR) begin
          ctrl.gra    = 1'b1;
          ctrl.r_out  = 1'b1;
          ctrl.con_in = 1'b1;
        end
      end
      T4: begin
        ctrl.pc_out = 1'b1;
        ctrl.y_in   = 1'b1;
      end
      T5: begin
        ctrl.c_out = 1'b1;
        ctrl.add   = 1'b1;
        ctrl.z_in  = 1'b1;
      end
      T6: begin
        ctrl.zlow_out = 1'b1;
        ctrl.pc_in    = con_out;
      end
      HALTED: ctrl.halted = 1'b1;
      default: ctrl = '0;
    endcase
  end

endmodule

// File: rtl/branch_sequencer.sv
// Fetch/decode/branch control sequencer: T0-T3 fetch+decode, T4-T6 branch, HALTED park state.
// Latency: NOP 4 cycles, BR 7 cycles, plus one per mem_done-low cycle in T1.
// Backpressure: stalls in T1 until mem_done; restarts from HALTED only on a run rising edge.
module branch_sequencer
  import branch_seq_pkg::*;
(
  input logic               clock,
  input logic               reset,
  branch_sequencer_if.slave bus
);

  state_t     state;
  state_t     state_nxt;
  logic       run_q;
  logic       t1_waited;
  logic [4:0] opcode;
  ctrl_t      ctrl;

  assign opcode = opcode_of(bus.IR);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= RESET_ST;
      run_q     <= 1'b0;
      t1_waited <= 1'b0;
    end else begin
      state     <= state_nxt;
      run_q     <= bus.run;
      t1_waited <= (state == T1) && (state_nxt == T1);
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      RESET_ST: if (bus.run) state_nxt = T0;
      T0:       state_nxt = T1;
      T1:       if (bus.mem_done) state_nxt = T2;
      T2:       state_nxt = T3;
      T3: begin
        case (opcode)
          BR:      state_nxt = T4;
          HALT:    state_nxt = HALTED;
          default: state_nxt = T0;
        endcase
      end
      T4:       state_nxt = T5;
      T5:       state_nxt = T6;
      T6:       state_nxt = T0;
      // A run level held from before the halt must not restart the sequencer.
      HALTED:   if (bus.run && !run_q) state_nxt = T0;
      default:  state_nxt = RESET_ST;
    endcase
  end

  branch_seq_decode u_decode (
    .state    (state),
    .opcode   (opcode),
    .con_out  (bus.CON_out),
    .first_t1 (!t1_waited),
    .ctrl     (ctrl)
  );

  assign bus.state        = state;
  assign bus.PCout        = ctrl.pc_out;
  assign bus.MARin        = ctrl.mar_in;
  assign bus.IncPC        = ctrl.inc_pc;
  assign bus.Zin          = ctrl.z_in;
  assign bus.Zlowout      = ctrl.zlow_out;
  assign bus.PCin         = ctrl.pc_in;
  assign bus.Read         = ctrl.read;
  assign bus.MDRin        = ctrl.mdr_in;
  assign bus.MDRout       = ctrl.mdr_out;
  assign bus.IRin         = ctrl.ir_in;
  assign bus.Gra          = ctrl.gra;
  assign bus.Rout         = ctrl.r_out;
  assign bus.CONin        = ctrl.con_in;
  assign bus.con_FF_Reset = ctrl.con_ff_reset;
  assign bus.Yin          = ctrl.y_in;
  assign bus.Cout         = ctrl.c_out;
  assign bus.ADD          = ctrl.add;
  assign bus.halted       = ctrl.halted;

endmodule

// File: tb/tb_branch_sequencer.sv
// Randomized bench: instruction-level model expands each instruction into a per-cycle trace
// that a negedge monitor compares against the DUT state and control lines.
module tb_branch_sequencer;

  localparam logic [3:0] S_RST = 4'd0, S_T0 = 4'd1, S_T1 = 4'd2, S_T2 = 4'd3, S_T3 = 4'd4;
  localparam logic [3:0] S_T4 = 4'd5, S_T5 = 4'd6, S_T6 = 4'd7, S_HLT = 4'd8;
  localparam logic [4:0] O_BR = 5'b10010, O_NOP = 5'b11010, O_HALT = 5'b11011;

  localparam logic [17:0] C_PCOUT = 18'h20000, C_MARIN = 18'h10000, C_INCPC = 18'h08000;
  localparam logic [17:0] C_ZIN = 18'h04000, C_ZLOW = 18'h02000, C_PCIN = 18'h01000;
  localparam logic [17:0] C_READ = 18'h00800, C_MDRIN = 18'h00400, C_MDROUT = 18'h00200;
  localparam logic [17:0] C_IRIN = 18'h00100, C_GRA = 18'h00080, C_ROUT = 18'h00040;
  localparam logic [17:0] C_CONIN = 18'h00020, C_CFFR = 18'h00010, C_YIN = 18'h00008;
  localparam logic [17:0] C_COUT = 18'h00004, C_ADD = 18'h00002, C_HALTED = 18'h00001;
  localparam logic [17:0] C_DRIVERS = C_PCOUT | C_ZLOW | C_MDROUT | C_ROUT | C_COUT;

  typedef struct packed {
    logic [3:0]  st;
    logic [17:0] ctrl;
    logic [31:0] ir;
    logic        con;
    logic        md;
    logic        run;
  } step_t;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   errors = 0;
  int   checks = 0;

  step_t plan[$];
  step_t exp_q[$];

  branch_sequencer_if bif();

  branch_sequencer dut (
    .clock (clock),
    .reset (reset),
    .bus   (bif.slave)
  );

  always #5 clock = ~clock;

  logic [17:0] act;
  assign act = {bif.PCout, bif.MARin, bif.IncPC, bif.Zin, bif.Zlowout, bif.PCin,
                bif.Read, bif.MDRin, bif.MDRout, bif.IRin, bif.Gra, bif.Rout,
                bif.CONin, bif.con_FF_Reset, bif.Yin, bif.Cout, bif.ADD, bif.halted};

  function automatic step_t mk(input logic [3:0] st, input logic [17:0] c);
    step_t s;
    s.st   = st;
    s.ctrl = c;
    s.ir   = $urandom;
    s.con  = 1'($urandom_range(0, 1));
    s.md   = 1'($urandom_range(0, 1));
    s.run  = 1'($urandom_range(0, 1));
    return s;
  endfunction

  function automatic void add_idle(input int n, input logic run_val);
    step_t s;
    for (int i = 0; i < n; i++) begin
      s = mk(S_RST, 18'h0);
      s.run = run_val;
      plan.push_back(s);
    end
  endfunction

  // One instruction as seen by the control unit: fetch, decode, then branch or halt tail.
  function automatic void add_instr(input logic [31:0] ir3, input int waits,
                                    input logic con, input int hold);
    step_t s;
    logic [4:0] op;
    op = ir3[31:27];
    plan.push_back(mk(S_T0, C_PCOUT | C_MARIN | C_INCPC | C_ZIN));
    for (int i = 0; i <= waits; i++) begin
      s = mk(S_T1, C_ZLOW | C_READ | C_MDRIN | ((i == 0) ? C_PCIN : 18'h0));
      s.md = (i == waits);
      plan.push_back(s);
    end
    plan.push_back(mk(S_T2, C_MDROUT | C_IRIN | C_CFFR));
    s = mk(S_T3, (op == O_BR) ? (C_GRA | C_ROUT | C_CONIN) : 18'h0);
    s.ir  = ir3;
    s.run = 1'b1;
    plan.push_back(s);
    if (op == O_BR) begin
      plan.push_back(mk(S_T4, C_PCOUT | C_YIN));
      plan.push_back(mk(S_T5, C_COUT | C_ADD | C_ZIN));
      s = mk(S_T6, C_ZLOW | (con ? C_PCIN : 18'h0));
      s.con = con;
      plan.push_back(s);
    end else if (op == O_HALT) begin
      for (int i = 0; i < hold; i++) begin
        s = mk(S_HLT, C_HALTED);
        s.run = 1'b1;
        plan.push_back(s);
      end
      s = mk(S_HLT, C_HALTED);
      s.run = 1'b0;
      plan.push_back(s);
      s = mk(S_HLT, C_HALTED);
      s.run = 1'b1;
      plan.push_back(s);
    end
  endfunction

  task automatic check_reset_now(input string tag);
    checks++;
    if (bif.state !== S_RST) begin
      errors++;
      $display("FAIL %s state: got %0d want %0d at %0t", tag, bif.state, S_RST, $time);
    end
    checks++;
    if (act !== 18'h0) begin
      errors++;
      $display("FAIL %s outputs: got %05h want 00000 at %0t", tag, act, $time);
    end
  endtask

  task automatic run_plan(input bit abort_t5);
    step_t s;
    while (plan.size() > 0) begin
      s = plan.pop_front();
      @(posedge clock);
      #1;
      bif.run      = s.run;
      bif.IR       = s.ir;
      bif.CON_out  = s.con;
      bif.mem_done = s.md;
      exp_q.push_back(s);
      if (abort_t5 && s.st == S_T5) begin
        plan.delete();
        @(negedge clock);
        #1;
        bif.run = 1'b0;
        reset   = 1'b1;
        #1;
        check_reset_now("async_reset_mid_t5");
        @(posedge clock);
        #1;
        reset = 1'b0;
      end
    end
  endtask

  always @(negedge clock) begin
    step_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (bif.state !== e.st) begin
        errors++;
        $display("FAIL state: got %0d want %0d at %0t", bif.state, e.st, $time);
      end
      checks++;
      if (act !== e.ctrl) begin
        errors++;
        $display("FAIL ctrl (state %0d): got %05h want %05h at %0t", e.st, act, e.ctrl, $time);
      end
    end
    checks++;
    if ($countones(act & C_DRIVERS) > 1) begin
      errors++;
      $display("FAIL bus_drivers: got %05h want at most one driver at %0t",
               act & C_DRIVERS, $time);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1);
  end

  initial begin
    logic [31:0] ir3;
    int sel;
    bif.run      = 1'b0;
    bif.IR       = 32'h0;
    bif.CON_out  = 1'b0;
    bif.mem_done = 1'b0;
    #3;
    check_reset_now("power_on_reset");
    @(posedge clock);
    #1;
    reset = 1'b0;

    add_idle(2, 1'b0);
    add_idle(1, 1'b1);
    add_instr({O_NOP, 27'h0000123}, 0, 1'b0, 0);
    add_instr(32'h9018_0000, 0, 1'b1, 0);
    add_instr(32'h9018_0000, 0, 1'b0, 0);
    add_instr({O_NOP, 27'h5a5a5a5}, 3, 1'b0, 0);
    add_instr({O_HALT, 27'h0}, 1, 1'b0, 3);
    add_instr({O_NOP, 27'h0}, 0, 1'b0, 0);
    run_plan(1'b0);

    add_instr(32'h9018_0000, 2, 1'b1, 0);
    run_plan(1'b1);
    add_idle(1, 1'b0);
    add_idle(1, 1'b1);
    add_instr({5'b00001, 27'h0}, 0, 1'b0, 0);
    run_plan(1'b0);

    for (int n = 0; n < 40; n++) begin
      ir3 = $urandom;
      sel = $urandom_range(0, 3);
      case (sel)
        0:       ir3[31:27] = O_BR;
        1:       ir3[31:27] = O_NOP;
        2:       ir3[31:27] = O_HALT;
        default: ;
      endcase
      add_instr(ir3, $urandom_range(0, 4), 1'($urandom_range(0, 1)), $urandom_range(1, 3));
      run_plan(1'b0);
    end

    @(posedge clock);
    @(negedge clock);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending want 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
